// File: rtl/spu_pkg.sv
// Shared types and constants for the SPU register-fetch slice.
// Quadword, register-address, opcode and immediate types use the
// big-endian [0:N] bit numbering of the rest of the pipeline.
package spu_pkg;

    typedef logic [0:127] quad_t;
    typedef logic [0:6]   reg_addr_t;
    typedef logic [0:10]  opcode_t;
    typedef logic [0:17]  imm_t;

    localparam int         NUM_REGS   = 128;
    localparam opcode_t    NOP_OPCODE = '0;
    localparam logic [2:0] NOP_FORMAT = 3'd0;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register in-flight scoreboard for the register-fetch stage.
// Each register has a down-counter loaded with RESULT_LATENCY when an
// instruction writing it issues; a nonzero count means the result is
// still in flight. CNT_W must be wide enough that 2^CNT_W > RESULT_LATENCY.
// Optional feature macro: REG_FETCH_WB_BYPASS_EN (count==1 is resolved by
// the write-back bypass instead of blocking).
module reg_scoreboard
    import spu_pkg::*;
#(
    parameter int RESULT_LATENCY = 4,
    parameter int CNT_W          = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load_en,
    input  logic [6:0] load_addr,
    input  logic [6:0] src_a_addr,
    input  logic [6:0] src_b_addr,
    input  logic [6:0] src_c_addr,
    input  logic       src_a_used,
    input  logic       src_b_used,
    input  logic       src_c_used,
    output logic       src_a_blocked,
    output logic       src_b_blocked,
    output logic       src_c_blocked
);

`ifdef REG_FETCH_WB_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(RESULT_LATENCY);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q [NUM_REGS];
    logic [CNT_W-1:0] cnt_d [NUM_REGS];

    // Saturating decrement for every entry; a new issue reloads its destination (newest write wins).
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? (cnt_q[r] - ONE) : '0;
        end
        if (load_en) begin
            cnt_d[load_addr] = LOAD_VAL;
        end
    end

    // Counter array state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A read is blocked while the result is more than one cycle away, or on its arrival cycle when it cannot be bypassed.
    function automatic logic is_blocked(input logic used, input logic [CNT_W-1:0] cnt);
        return used && ((cnt > ONE) || ((cnt == ONE) && !BYPASS_EN));
    endfunction

    assign src_a_blocked = is_blocked(src_a_used, cnt_q[src_a_addr]);
    assign src_b_blocked = is_blocked(src_b_used, cnt_q[src_b_addr]);
    assign src_c_blocked = is_blocked(src_c_used, cnt_q[src_c_addr]);

endmodule

// File: rtl/reg_fetch_stage.sv
// Register-file / forwarding stage feeding the execute units.
// Holds the 128 x 128-bit register file with two write-back ports, reads
// ra/rb/rc, stalls decode on RAW hazards via reg_scoreboard, and registers
// the operand/control bundle to execute one cycle after acceptance.
// Optional feature macro: REG_FETCH_WB_BYPASS_EN enables forwarding of the
// same-cycle write-back ports into the operand read.
module reg_fetch_stage
    import spu_pkg::*;
#(
    parameter int RESULT_LATENCY = 4,
    parameter int CNT_W          = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         id_valid,
    output logic         id_stall,
    input  logic [10:0]  id_op_code,
    input  logic [2:0]   id_instr_format,
    input  logic [6:0]   id_dest_reg_addr,
    input  logic [6:0]   id_src_a_addr,
    input  logic [6:0]   id_src_b_addr,
    input  logic [6:0]   id_src_c_addr,
    input  logic         id_src_a_used,
    input  logic         id_src_b_used,
    input  logic         id_src_c_used,
    input  logic [17:0]  id_imm_value,
    input  logic         id_enable_reg_write,
    input  logic         branch_is_taken,
    input  logic [127:0] wb_even_data,
    input  logic [127:0] wb_odd_data,
    input  logic [6:0]   wb_even_addr,
    input  logic [6:0]   wb_odd_addr,
    input  logic         wb_even_en,
    input  logic         wb_odd_en,
    output logic [10:0]  ex_op_code,
    output logic [2:0]   ex_instr_format,
    output logic [6:0]   ex_dest_reg_addr,
    output logic [127:0] ex_src_reg_a,
    output logic [127:0] ex_src_reg_b,
    output logic [127:0] ex_src_reg_c,
    output logic [17:0]  ex_imm_value,
    output logic         ex_enable_reg_write
);

    quad_t regfile_q [NUM_REGS];
    quad_t regfile_d [NUM_REGS];

    logic         blocked_a, blocked_b, blocked_c;
    logic         accept;
    logic         sb_load;

    logic [10:0]  ex_op_code_q, ex_op_code_d;
    logic [2:0]   ex_instr_format_q, ex_instr_format_d;
    logic [6:0]   ex_dest_reg_addr_q, ex_dest_reg_addr_d;
    quad_t        ex_src_reg_a_q, ex_src_reg_a_d;
    quad_t        ex_src_reg_b_q, ex_src_reg_b_d;
    quad_t        ex_src_reg_c_q, ex_src_reg_c_d;
    logic [17:0]  ex_imm_value_q, ex_imm_value_d;
    logic         ex_enable_reg_write_q, ex_enable_reg_write_d;

    // A taken branch squashes the decode slot, so it neither stalls nor issues.
    assign id_stall = id_valid & (blocked_a | blocked_b | blocked_c) & ~branch_is_taken;
    assign accept   = id_valid & ~id_stall & ~branch_is_taken;
    assign sb_load  = accept & id_enable_reg_write;

    reg_scoreboard #(
        .RESULT_LATENCY (RESULT_LATENCY),
        .CNT_W          (CNT_W)
    ) u_scoreboard (
        .clock         (clock),
        .reset         (reset),
        .load_en       (sb_load),
        .load_addr     (id_dest_reg_addr),
        .src_a_addr    (id_src_a_addr),
        .src_b_addr    (id_src_b_addr),
        .src_c_addr    (id_src_c_addr),
        .src_a_used    (id_src_a_used),
        .src_b_used    (id_src_b_used),
        .src_c_used    (id_src_c_used),
        .src_a_blocked (blocked_a),
        .src_b_blocked (blocked_b),
        .src_c_blocked (blocked_c)
    );

    // Operand read: odd write-back beats even, which beats the stored value.
    function automatic quad_t select_operand(input logic [6:0] src);
`ifdef REG_FETCH_WB_BYPASS_EN
        if (wb_odd_en && (wb_odd_addr == src)) begin
            return wb_odd_data;
        end else if (wb_even_en && (wb_even_addr == src)) begin
            return wb_even_data;
        end else begin
            return regfile_q[src];
        end
`else
        return regfile_q[src];
`endif
    endfunction

    // Register-file update; odd port is applied last so it wins an address collision.
    always_comb begin
        regfile_d = regfile_q;
        if (wb_even_en) begin
            regfile_d[wb_even_addr] = wb_even_data;
        end
        if (wb_odd_en) begin
            regfile_d[wb_odd_addr] = wb_odd_data;
        end
    end

    // Register-file storage.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regfile_q[r] <= '0;
            end
        end else begin
            regfile_q <= regfile_d;
        end
    end

    // Next execute bundle: the accepted instruction, otherwise an all-zero NOP bubble.
    always_comb begin
        ex_op_code_d          = NOP_OPCODE;
        ex_instr_format_d     = NOP_FORMAT;
        ex_dest_reg_addr_d    = '0;
        ex_src_reg_a_d        = '0;
        ex_src_reg_b_d        = '0;
        ex_src_reg_c_d        = '0;
        ex_imm_value_d        = '0;
        ex_enable_reg_write_d = 1'b0;
        if (accept) begin
            ex_op_code_d          = id_op_code;
            ex_instr_format_d     = id_instr_format;
            ex_dest_reg_addr_d    = id_dest_reg_addr;
            ex_src_reg_a_d        = select_operand(id_src_a_addr);
            ex_src_reg_b_d        = select_operand(id_src_b_addr);
            ex_src_reg_c_d        = select_operand(id_src_c_addr);
            ex_imm_value_d        = id_imm_value;
            ex_enable_reg_write_d = id_enable_reg_write;
        end
    end

    // Execute bundle registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex_op_code_q          <= '0;
            ex_instr_format_q     <= '0;
            ex_dest_reg_addr_q    <= '0;
            ex_src_reg_a_q        <= '0;
            ex_src_reg_b_q        <= '0;
            ex_src_reg_c_q        <= '0;
            ex_imm_value_q        <= '0;
            ex_enable_reg_write_q <= 1'b0;
        end else begin
            ex_op_code_q          <= ex_op_code_d;
            ex_instr_format_q     <= ex_instr_format_d;
            ex_dest_reg_addr_q    <= ex_dest_reg_addr_d;
            ex_src_reg_a_q        <= ex_src_reg_a_d;
            ex_src_reg_b_q        <= ex_src_reg_b_d;
            ex_src_reg_c_q        <= ex_src_reg_c_d;
            ex_imm_value_q        <= ex_imm_value_d;
            ex_enable_reg_write_q <= ex_enable_reg_write_d;
        end
    end

    assign ex_op_code          = ex_op_code_q;
    assign ex_instr_format     = ex_instr_format_q;
    assign ex_dest_reg_addr    = ex_dest_reg_addr_q;
    assign ex_src_reg_a        = ex_src_reg_a_q;
    assign ex_src_reg_b        = ex_src_reg_b_q;
    assign ex_src_reg_c        = ex_src_reg_c_q;
    assign ex_imm_value        = ex_imm_value_q;
    assign ex_enable_reg_write = ex_enable_reg_write_q;

endmodule

// File: tb/tb_reg_fetch_stage.sv
// Directed testbench for reg_fetch_stage with hand-computed expectations.
// Builds with or without REG_FETCH_WB_BYPASS_EN; expectations follow the macro.
module tb_reg_fetch_stage;

    localparam logic [127:0] D5   = 128'h0102030405060708090a0b0c0d0e0f10;
    localparam logic [127:0] D9   = 128'h99990000_12345678_9abcdef0_0000aaaa;
    localparam logic [127:0] DAA  = {16{8'hAA}};
    localparam logic [127:0] D55  = {16{8'h55}};
    localparam logic [10:0]  CNTB = 11'b01010110100;

`ifdef REG_FETCH_WB_BYPASS_EN
    localparam int           EXP_STALL   = 3;
    localparam logic [127:0] EXP_SAME_WB = D55;
`else
    localparam int           EXP_STALL   = 4;
    localparam logic [127:0] EXP_SAME_WB = 128'h0;
`endif

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         id_valid;
    logic         id_stall;
    logic [10:0]  id_op_code;
    logic [2:0]   id_instr_format;
    logic [6:0]   id_dest_reg_addr;
    logic [6:0]   id_src_a_addr, id_src_b_addr, id_src_c_addr;
    logic         id_src_a_used, id_src_b_used, id_src_c_used;
    logic [17:0]  id_imm_value;
    logic         id_enable_reg_write;
    logic         branch_is_taken;
    logic [127:0] wb_even_data, wb_odd_data;
    logic [6:0]   wb_even_addr, wb_odd_addr;
    logic         wb_even_en, wb_odd_en;
    logic [10:0]  ex_op_code;
    logic [2:0]   ex_instr_format;
    logic [6:0]   ex_dest_reg_addr;
    logic [127:0] ex_src_reg_a, ex_src_reg_b, ex_src_reg_c;
    logic [17:0]  ex_imm_value;
    logic         ex_enable_reg_write;

    int checkCount = 0;
    int errorCount = 0;
    int stallCycles;

    reg_fetch_stage dut (
        .clock               (clock),
        .reset               (reset),
        .id_valid            (id_valid),
        .id_stall            (id_stall),
        .id_op_code          (id_op_code),
        .id_instr_format     (id_instr_format),
        .id_dest_reg_addr    (id_dest_reg_addr),
        .id_src_a_addr       (id_src_a_addr),
        .id_src_b_addr       (id_src_b_addr),
        .id_src_c_addr       (id_src_c_addr),
        .id_src_a_used       (id_src_a_used),
        .id_src_b_used       (id_src_b_used),
        .id_src_c_used       (id_src_c_used),
        .id_imm_value        (id_imm_value),
        .id_enable_reg_write (id_enable_reg_write),
        .branch_is_taken     (branch_is_taken),
        .wb_even_data        (wb_even_data),
        .wb_odd_data         (wb_odd_data),
        .wb_even_addr        (wb_even_addr),
        .wb_odd_addr         (wb_odd_addr),
        .wb_even_en          (wb_even_en),
        .wb_odd_en           (wb_odd_en),
        .ex_op_code          (ex_op_code),
        .ex_instr_format     (ex_instr_format),
        .ex_dest_reg_addr    (ex_dest_reg_addr),
        .ex_src_reg_a        (ex_src_reg_a),
        .ex_src_reg_b        (ex_src_reg_b),
        .ex_src_reg_c        (ex_src_reg_c),
        .ex_imm_value        (ex_imm_value),
        .ex_enable_reg_write (ex_enable_reg_write)
    );

    // 10-time-unit clock.
    always #5 clock = ~clock;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Drives one decode slot; inputs change 1 unit after the clock edge.
    task automatic applyStimulus(input logic valid, input logic [10:0] op, input logic [2:0] fmt,
                                 input logic [6:0] dest, input logic [6:0] ra, input logic ua,
                                 input logic [6:0] rb, input logic ub, input logic [17:0] imm,
                                 input logic we);
        id_valid            = valid;
        id_op_code          = op;
        id_instr_format     = fmt;
        id_dest_reg_addr    = dest;
        id_src_a_addr       = ra;
        id_src_a_used       = ua;
        id_src_b_addr       = rb;
        id_src_b_used       = ub;
        id_src_c_addr       = 7'd0;
        id_src_c_used       = 1'b0;
        id_imm_value        = imm;
        id_enable_reg_write = we;
    endtask

    task automatic clearWriteBack();
        wb_even_en   = 1'b0;
        wb_odd_en    = 1'b0;
        wb_even_addr = 7'd0;
        wb_odd_addr  = 7'd0;
        wb_even_data = '0;
        wb_odd_data  = '0;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 11'd0, 3'd0, 7'd0, 7'd0, 1'b0, 7'd0, 1'b0, 18'd0, 1'b0);
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    // Holds a dependent instruction in decode and counts stall cycles (bounded).
    // When driveWb is set, the producer's result appears on the even port on the count==1 cycle.
    task automatic countStall(input logic [6:0] src, input logic driveWb, output int cycles);
        cycles = 0;
        applyStimulus(1'b1, 11'h0A5, 3'd1, 7'd60, src, 1'b1, 7'd0, 1'b0, 18'd0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            clearWriteBack();
            if (driveWb && k == 3) begin
                wb_even_en   = 1'b1;
                wb_even_addr = src;
                wb_even_data = D9;
            end
            #1;
            if (!id_stall) break;
            cycles++;
            nextCycle();
        end
    endtask

    initial begin
        branch_is_taken = 1'b0;
        clearWriteBack();
        idle();
        #1 reset = 1'b1;
        #1;
        checkOutput("reset_stall", {127'd0, id_stall}, 128'd0);
        checkOutput("reset_ex_op", {117'd0, ex_op_code}, 128'd0);
        checkOutput("reset_ex_a", ex_src_reg_a, 128'd0);
        nextCycle();
        nextCycle();
        reset = 1'b0;
        nextCycle();

        // Write r5 through the even port, then read it as ra.
        wb_even_en = 1'b1; wb_even_addr = 7'd5; wb_even_data = D5;
        nextCycle();
        clearWriteBack();
        applyStimulus(1'b1, CNTB, 3'd2, 7'd20, 7'd5, 1'b1, 7'd0, 1'b0, 18'h1_2345, 1'b0);
        #1;
        checkOutput("r5_no_stall", {127'd0, id_stall}, 128'd0);
        nextCycle();
        checkOutput("r5_ex_a", ex_src_reg_a, D5);
        checkOutput("r5_ex_op", {117'd0, ex_op_code}, {117'd0, CNTB});
        checkOutput("r5_ex_fmt", {125'd0, ex_instr_format}, 128'd2);
        checkOutput("r5_ex_dest", {121'd0, ex_dest_reg_addr}, 128'd20);
        checkOutput("r5_ex_imm", {110'd0, ex_imm_value}, 128'h1_2345);
        idle();
        nextCycle();
        checkOutput("bubble_op", {117'd0, ex_op_code}, 128'd0);

        // RAW: producer writes r9, dependent reads r9 the next cycle.
        applyStimulus(1'b1, 11'h100, 3'd3, 7'd9, 7'd0, 1'b0, 7'd0, 1'b0, 18'd0, 1'b1);
        nextCycle();
        checkOutput("prod_ex_we", {127'd0, ex_enable_reg_write}, 128'd1);
        countStall(7'd9, 1'b1, stallCycles);
        checkOutput("raw_stall_cycles", 128'(stallCycles), 128'(EXP_STALL));
        nextCycle();
        clearWriteBack();
        idle();
        checkOutput("raw_ex_a", ex_src_reg_a, D9);
        checkOutput("raw_ex_dest", {121'd0, ex_dest_reg_addr}, 128'd60);

        // Both write-back ports hit r12 while r12 is read.
        wb_even_en = 1'b1; wb_even_addr = 7'd12; wb_even_data = DAA;
        wb_odd_en  = 1'b1; wb_odd_addr  = 7'd12; wb_odd_data  = D55;
        applyStimulus(1'b1, 11'h011, 3'd1, 7'd21, 7'd12, 1'b1, 7'd0, 1'b0, 18'd0, 1'b0);
        nextCycle();
        clearWriteBack();
        checkOutput("same_addr_ex_a", ex_src_reg_a, EXP_SAME_WB);
        nextCycle();
        checkOutput("same_addr_rf", ex_src_reg_a, D55);
        idle();
        nextCycle();

        // Taken branch during a stall: squash, no stall, no scoreboard load.
        applyStimulus(1'b1, 11'h200, 3'd1, 7'd7, 7'd0, 1'b0, 7'd0, 1'b0, 18'd0, 1'b1);
        nextCycle();
        applyStimulus(1'b1, 11'h201, 3'd1, 7'd30, 7'd7, 1'b1, 7'd0, 1'b0, 18'h3, 1'b1);
        #1;
        checkOutput("br_pre_stall", {127'd0, id_stall}, 128'd1);
        branch_is_taken = 1'b1;
        #1;
        checkOutput("br_stall", {127'd0, id_stall}, 128'd0);
        nextCycle();
        branch_is_taken = 1'b0;
        checkOutput("br_ex_op", {117'd0, ex_op_code}, 128'd0);
        checkOutput("br_ex_we", {127'd0, ex_enable_reg_write}, 128'd0);
        checkOutput("br_ex_imm", {110'd0, ex_imm_value}, 128'd0);
        applyStimulus(1'b1, 11'h202, 3'd1, 7'd31, 7'd30, 1'b1, 7'd0, 1'b0, 18'd0, 1'b0);
        #1;
        checkOutput("br_no_sb_load", {127'd0, id_stall}, 128'd0);
        nextCycle();
        idle();
        for (int i = 0; i < 6; i++) nextCycle();

        // WAW: two writes to r3 two cycles apart; the read must wait for the second.
        applyStimulus(1'b1, 11'h300, 3'd1, 7'd3, 7'd0, 1'b0, 7'd0, 1'b0, 18'd0, 1'b1);
        nextCycle();
        idle();
        nextCycle();
        applyStimulus(1'b1, 11'h301, 3'd1, 7'd3, 7'd0, 1'b0, 7'd0, 1'b0, 18'd0, 1'b1);
        nextCycle();
        countStall(7'd3, 1'b0, stallCycles);
        checkOutput("waw_stall_cycles", 128'(stallCycles), 128'(EXP_STALL));
        nextCycle();
        idle();
        for (int i = 0; i < 6; i++) nextCycle();

        // Reset asserted mid-stall clears everything without waiting for a clock edge.
        applyStimulus(1'b1, 11'h400, 3'd2, 7'd40, 7'd0, 1'b0, 7'd0, 1'b0, 18'h7, 1'b1);
        nextCycle();
        applyStimulus(1'b1, 11'h401, 3'd1, 7'd41, 7'd40, 1'b1, 7'd0, 1'b0, 18'd0, 1'b0);
        #1;
        checkOutput("rst_pre_stall", {127'd0, id_stall}, 128'd1);
        checkOutput("rst_pre_ex_op", {117'd0, ex_op_code}, 128'h400);
        reset = 1'b1;
        #1;
        checkOutput("rst_async_stall", {127'd0, id_stall}, 128'd0);
        checkOutput("rst_async_ex_op", {117'd0, ex_op_code}, 128'd0);
        checkOutput("rst_async_ex_dest", {121'd0, ex_dest_reg_addr}, 128'd0);
        nextCycle();
        reset = 1'b0;
        applyStimulus(1'b1, 11'h402, 3'd1, 7'd42, 7'd40, 1'b1, 7'd5, 1'b1, 18'd0, 1'b0);
        #1;
        checkOutput("post_rst_stall", {127'd0, id_stall}, 128'd0);
        nextCycle();
        idle();
        checkOutput("post_rst_op", {117'd0, ex_op_code}, 128'h402);
        checkOutput("post_rst_r5", ex_src_reg_b, 128'd0);
        nextCycle();

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/reg_fetch_stage.md
Name: reg_fetch_stage

Overview:
- Register-file/forwarding stage directly upstream of the byte execution unit and its sibling even/odd units.
- Holds the 128 x 128-bit register file with two write-back ports, and reads three source operands (ra, rb, rc).
- Bypasses same-cycle write-back results and tracks in-flight destinations in a per-register scoreboard; stalls decode on unresolved RAW hazards.
- Presents a registered operand/control bundle to execute, one cycle after acceptance.

Parameters:
- RESULT_LATENCY, 4, cycles from issue (ex_* valid) to the result appearing on a wb port; the scoreboard load value.
- CNT_W, 3, scoreboard counter width; must satisfy 2^CNT_W > RESULT_LATENCY.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- id_valid  in  1  decode presents an instruction
- id_stall  out  1  hazard stall; decode must hold its inputs stable
- id_op_code  in  11  decoded opcode [0:10]
- id_instr_format  in  3  instruction format
- id_dest_reg_addr  in  7  rt address
- id_src_a_addr, id_src_b_addr, id_src_c_addr  in  7 each  ra/rb/rc addresses
- id_src_a_used, id_src_b_used, id_src_c_used  in  1 each  operand actually read (hazard-qualified)
- id_imm_value  in  18  immediate
- id_enable_reg_write  in  1  instruction writes rt
- branch_is_taken  in  1  flush
- wb_even_data / wb_odd_data  in  128 each  write-back data
- wb_even_addr / wb_odd_addr  in  7 each  write-back address
- wb_even_en / wb_odd_en  in  1 each  write-back enable
- ex_op_code  out  11  to execute
- ex_instr_format  out  3  to execute
- ex_dest_reg_addr  out  7  to execute
- ex_src_reg_a, ex_src_reg_b, ex_src_reg_c  out  128 each  operand values
- ex_imm_value  out  18  to execute
- ex_enable_reg_write  out  1  to execute

Behaviour:
- Reset (asynchronous, active-high):
  - All ex_* outputs go to 0, which is a NOP (format 0, opcode 0).
  - All register-file entries and all scoreboard counters go to 0; id_stall=0.
- Write:
  - At each posedge, when wb_even_en=1, regfile[wb_even_addr] <= wb_even_data; likewise for the odd port.
  - If both ports target the same address, odd wins.
- Scoreboard:
  - cnt[r] decrements by 1 each cycle while nonzero (saturates at 0).
  - On issue of an instruction with id_enable_reg_write=1, cnt[dest] <= RESULT_LATENCY. This overrides the decrement (WAW: newest wins).
- Hazard:
  - A used source s is blocked when cnt[s]>1, or when cnt[s]==1 and bypass is disabled.
  - id_stall is combinational = id_valid & any blocked source & ~branch_is_taken.
- Operand select, in priority order:
  - wb_odd port match (en=1 and addr==s), then
  - wb_even port match, then
  - regfile[s].
- Issue (posedge, no reset):
  - branch_is_taken=1: ex_* <= NOP and ex_enable_reg_write=0; no scoreboard load. This takes precedence over stall and valid.
  - Else id_valid=1 and id_stall=0: ex_* <= the decode fields plus selected operands. One-cycle latency.
  - Else (stall or no valid): ex_* <= NOP bubble with all fields 0.
- NOP from decode (format 0, opcode 0) passes through; scoreboard is loaded only when id_enable_reg_write=1.
- Reset asserted mid-stall: state clears immediately; after release, the first valid instruction issues without stall.

Optional Feature:
- Macro REG_FETCH_WB_BYPASS_EN.
- Defined:
  - Write-back port bypass is active.
  - cnt==1 sources are not blocked and take the wb port value.
  - Back-to-back dependent stall = RESULT_LATENCY-1 cycles.
- Undefined:
  - No bypass; operands come from the regfile only.
  - cnt==1 also blocks, so the stall is RESULT_LATENCY cycles.

Decomposition:
- Package spu_pkg:
  - quad_t (logic [0:127]), reg_addr_t (logic [0:6]), opcode_t (logic [0:10]), imm_t (logic [0:17]).
  - NOP_OPCODE=0, NOP_FORMAT=0, NUM_REGS=128.
- Sub-module reg_scoreboard:
  - Counter array, load/decrement, and the per-source blocked outputs for three sources.

Test Plan:
- Reset mid-stall → all ex_* outputs 0, id_stall=0 immediately (asynchronous), regfile reads 0.
- Write regfile[5]=0x0102…10 via the even port, then issue ra=5, cntb → ex_src_reg_a=0x0102…10 and ex_op_code=11'b01010110100, one cycle after acceptance.
- Issue rt=9, then a dependent instruction with ra=9 the next cycle, RESULT_LATENCY=4:
  - With the macro: id_stall high 3 cycles; the operand is taken from wb_even_data on the cycle it appears.
  - Without the macro: stall 4 cycles.
- Both wb ports write addr 12 (even=0xAA…, odd=0x55…) while ra=12 is read → ex_src_reg_a=0x55…; regfile[12]=0x55….
- branch_is_taken during a stall → ex_* is NOP, ex_enable_reg_write=0, id_stall=0, no scoreboard load.
- Two writes to rt=3 issued two cycles apart, then a read of r3 → stall tracks the second write's counter (WAW).
